password_lock_param: RTL and testbench

- Parametrised keypad-style code lock driven by N_SW debounced switch levels.
- Detects single-switch rising edges as digits and compares them in order against a CODE_LEN-digit code.
- Unlocks on a full match; counts failures and enters a timed lockout after MAX_FAIL consecutive failures.
- Sits between the debounce/oneshot front end and the LED/HEX display logic, all in one clock domain.

---
 rtl/password_lock_param.sv | 195 +++++++++++++++++++
 tb/tb_password_lock_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/password_lock_param.sv
// Keypad-style code lock: switch rising edges are digits, matched in order
// against CODE; repeated failures trigger a timed, blinking lockout.
module password_lock_param #(
   parameter int unsigned N_SW           = 10,
   parameter int unsigned CODE_LEN       = 4,
   parameter int unsigned DW             = $clog2(N_SW),
   parameter logic [CODE_LEN*DW-1:0] CODE = {4'd9, 4'd1, 4'd0, 4'd2},
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned LOCK_CYCLES    = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 500,
   parameter int unsigned BLINK_CYCLES   = 50
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N_SW-1:0]                    sw,
   input  logic                               clr,
   output logic [N_SW-1:0]                    led,
   output logic [2:0]                         state_o,
   output logic                               unlocked,
   output logic                               locked_out,
   output logic [$clog2(CODE_LEN+1)-1:0]      digit_cnt,
   output logic [$clog2(MAX_FAIL+1)-1:0]      fail_cnt
);

   localparam int unsigned CW = $clog2(CODE_LEN + 1);
   localparam int unsigned FW = $clog2(MAX_FAIL + 1);
   localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_ERROR   = 3'd2,
      S_OPEN    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_t;

   state_t            r_state, w_state_nxt;
   logic [N_SW-1:0]   r_sw_d;
   logic [CW-1:0]     r_digit, w_digit_nxt;
   logic [FW-1:0]     r_fail, w_fail_nxt, w_fail_inc;
   logic [LW-1:0]     r_lock_tmr, w_lock_nxt;
   logic [TW-1:0]     r_to_cnt, w_to_nxt;
   logic [BW-1:0]     r_blink_cnt, w_blink_cnt_nxt;
   logic              r_blink_on, w_blink_on_nxt;
   logic [N_SW-1:0]   r_led, w_led_nxt;
   logic              r_unlocked, r_locked_out;

   logic [N_SW-1:0]   w_edge;
   logic              w_press, w_single, w_ok;
   logic [DW-1:0]     w_digit_val, w_exp_digit;

   // Rising-edge detect, one-hot check, digit encode and expected-digit lookup
   always_comb begin
      w_edge      = sw & ~r_sw_d;
      w_press     = (w_edge != '0);
      w_single    = w_press && ((w_edge & (w_edge - 1'b1)) == '0);
      w_digit_val = '0;
      for (int i = 0; i < N_SW; i++) begin
         if (w_edge[i]) w_digit_val = DW'(i);
      end
      w_exp_digit = '0;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (r_digit == CW'(k)) w_exp_digit = CODE[k*DW +: DW];
      end
      w_ok       = w_single && (w_digit_val == w_exp_digit);
      w_fail_inc = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + 1'b1;
   end

   // Next-state, counters and registered-output decode
   always_comb begin
      w_state_nxt     = r_state;
      w_digit_nxt     = r_digit;
      w_fail_nxt      = r_fail;
      w_lock_nxt      = r_lock_tmr;
      w_to_nxt        = r_to_cnt;
      w_blink_cnt_nxt = r_blink_cnt;
      w_blink_on_nxt  = r_blink_on;
      w_led_nxt       = '0;

      case (r_state)
         S_IDLE, S_ENTRY: begin
            if (clr) begin
               w_state_nxt = S_IDLE;
               w_digit_nxt = '0;
            end else if (w_press) begin
               if (w_ok) begin
                  w_to_nxt = '0;
                  if (r_digit == CW'(CODE_LEN - 1)) begin
                     w_state_nxt = S_OPEN;
                     w_digit_nxt = CW'(CODE_LEN);
                     w_fail_nxt  = '0;
                  end else begin
                     w_state_nxt = S_ENTRY;
                     w_digit_nxt = r_digit + 1'b1;
                  end
               end else begin
                  w_fail_nxt  = w_fail_inc;
                  w_digit_nxt = '0;
                  if (w_fail_inc == FW'(MAX_FAIL)) begin
                     w_state_nxt     = S_LOCKOUT;
                     w_lock_nxt      = LW'(LOCK_CYCLES - 1);
                     w_blink_cnt_nxt = '0;
                     w_blink_on_nxt  = 1'b1;
                  end else begin
                     w_state_nxt = S_ERROR;
                  end
               end
            end else if (r_state == S_ENTRY) begin
               if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                  w_state_nxt = S_IDLE;
                  w_digit_nxt = '0;
                  w_to_nxt    = '0;
               end else begin
                  w_to_nxt = r_to_cnt + 1'b1;
               end
            end
         end
         S_ERROR: begin
            if (clr) w_state_nxt = S_IDLE;
         end
         S_OPEN: begin
            if (clr || w_press) begin
               w_state_nxt = S_IDLE;
               w_digit_nxt = '0;
            end
         end
         S_LOCKOUT: begin
            if (r_lock_tmr == '0) begin
               w_state_nxt = S_IDLE;
               w_fail_nxt  = '0;
            end else begin
               w_lock_nxt = r_lock_tmr - 1'b1;
            end
            if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
               w_blink_cnt_nxt = '0;
               w_blink_on_nxt  = ~r_blink_on;
            end else begin
               w_blink_cnt_nxt = r_blink_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      case (w_state_nxt)
         S_ENTRY: begin
            for (int i = 0; i < N_SW; i++) w_led_nxt[i] = (i < int'(w_digit_nxt));
         end
         S_ERROR: begin
            for (int i = 0; i < N_SW; i++) w_led_nxt[i] = i[0];
         end
         S_OPEN:    w_led_nxt = '1;
         S_LOCKOUT: w_led_nxt = {N_SW{w_blink_on_nxt}};
         default:   w_led_nxt = '0;
      endcase
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_sw_d       <= '1;
         r_digit      <= '0;
         r_fail       <= '0;
         r_lock_tmr   <= '0;
         r_to_cnt     <= '0;
         r_blink_cnt  <= '0;
         r_blink_on   <= 1'b0;
         r_led        <= '0;
         r_unlocked   <= 1'b0;
         r_locked_out <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sw_d       <= sw;
         r_digit      <= w_digit_nxt;
         r_fail       <= w_fail_nxt;
         r_lock_tmr   <= w_lock_nxt;
         r_to_cnt     <= w_to_nxt;
         r_blink_cnt  <= w_blink_cnt_nxt;
         r_blink_on   <= w_blink_on_nxt;
         r_led        <= w_led_nxt;
         r_unlocked   <= (w_state_nxt == S_OPEN);
         r_locked_out <= (w_state_nxt == S_LOCKOUT);
      end
   end

   assign led        = r_led;
   assign state_o    = r_state;
   assign unlocked   = r_unlocked;
   assign locked_out = r_locked_out;
   assign digit_cnt  = r_digit;
   assign fail_cnt   = r_fail;

endmodule

// File: tb/tb_password_lock_param.sv
// Bench for password_lock_param with default parameters: directed scenarios
// plus randomized traffic, all checked against a timestamp-based model.
module tb_password_lock_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clr = 1'b0;
   logic [9:0] sw  = '0;
   logic [9:0] led;
   logic [2:0] state_o;
   logic       unlocked, locked_out;
   logic [2:0] digit_cnt;
   logic [1:0] fail_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   password_lock_param dut (
      .clk(clk), .rst(rst), .sw(sw), .clr(clr), .led(led), .state_o(state_o),
      .unlocked(unlocked), .locked_out(locked_out), .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
   );

   // Reference model: states as plain ints, timers as cycle timestamps
   int         code [4] = '{2, 0, 1, 9};
   int         m_state, m_digits, m_fails, m_cyc, m_last, m_lock_start, m_n, m_d;
   logic [9:0] m_prev, m_e;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_state = 0; m_digits = 0; m_fails = 0; m_prev = '1; m_last = 0; m_lock_start = 0;
      end else begin
         m_cyc++;
         m_e = sw & ~m_prev;
         m_prev = sw;
         m_n = $countones(m_e);
         m_d = -1;
         for (int i = 0; i < 10; i++) if (m_e[i]) m_d = i;
         case (m_state)
            0, 1: begin
               if (clr) begin
                  m_state = 0; m_digits = 0;
               end else if (m_n > 0) begin
                  if (m_n == 1 && m_d == code[m_digits]) begin
                     m_digits++;
                     m_last = m_cyc;
                     if (m_digits == 4) begin m_state = 3; m_fails = 0; end
                     else m_state = 1;
                  end else begin
                     m_digits = 0;
                     if (m_fails < 3) m_fails++;
                     if (m_fails == 3) begin m_state = 4; m_lock_start = m_cyc; end
                     else m_state = 2;
                  end
               end else if (m_state == 1 && m_cyc - m_last >= 500) begin
                  m_state = 0; m_digits = 0;
               end
            end
            2: if (clr) m_state = 0;
            3: if (clr || m_n > 0) begin m_state = 0; m_digits = 0; end
            4: if (m_cyc - m_lock_start >= 1000) begin m_state = 0; m_fails = 0; end
            default: m_state = 0;
         endcase
      end
   end

   function automatic logic [19:0] exp_vec();
      logic [9:0] l;
      case (m_state)
         1:       l = 10'((1 << m_digits) - 1);
         2:       l = 10'b1010101010;
         3:       l = '1;
         4:       l = ((((m_cyc - m_lock_start) / 50) % 2) == 0) ? 10'h3ff : 10'h000;
         default: l = '0;
      endcase
      return {3'(m_state), (m_state == 3), (m_state == 4), 3'(m_digits), 2'(m_fails), l};
   endfunction

   function automatic logic [19:0] dut_vec();
      return {state_o, unlocked, locked_out, digit_cnt, fail_cnt, led};
   endfunction

   task automatic tap(input logic [9:0] m);
      sw = sw | m;
      @(negedge clk);
      sw = sw & ~m;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0; sw = '0; clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; sw = '0; clr = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (dut_vec() !== 20'h00000) $display("FAIL reset_const: got %h expected %h", dut_vec(), 20'h00000);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL reset_model: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_unlock();
      int seq [4];
      seq = '{2, 0, 1, 9};
      do_reset();
      for (int k = 0; k < 4; k++) begin
         tap(10'(1) << seq[k]);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL unlock_d%0d: got %h expected %h", k, dut_vec(), exp_vec());
         else n_pass++;
         n_checks++;
         if (digit_cnt !== 3'(k + 1)) $display("FAIL unlock_cnt%0d: got %0d expected %0d", k, digit_cnt, k + 1);
         else n_pass++;
         if (k < 3) repeat (3) @(negedge clk);
      end
      n_checks++;
      if ({state_o, unlocked, led, fail_cnt} !== {3'd3, 1'b1, 10'h3ff, 2'd0})
         $display("FAIL unlock_open: got %h expected %h", {state_o, unlocked, led, fail_cnt}, {3'd3, 1'b1, 10'h3ff, 2'd0});
      else n_pass++;
      repeat (2) @(negedge clk);
      tap(10'h020);
      n_checks++;
      if ({state_o, unlocked, digit_cnt} !== {3'd0, 1'b0, 3'd0})
         $display("FAIL unlock_relock: got %h expected %h", {state_o, unlocked, digit_cnt}, 7'h00);
      else n_pass++;
   endtask

   task automatic test_error();
      do_reset();
      tap(10'h004); tap(10'h001); tap(10'h010);
      n_checks++;
      if ({state_o, fail_cnt, led} !== {3'd2, 2'd1, 10'b1010101010})
         $display("FAIL error_enter: got %h expected %h", {state_o, fail_cnt, led}, {3'd2, 2'd1, 10'b1010101010});
      else n_pass++;
      tap(10'h004); tap(10'h080);
      n_checks++;
      if (dut_vec() !== exp_vec() || state_o !== 3'd2)
         $display("FAIL error_ignore: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
      pulse_clr();
      n_checks++;
      if ({state_o, fail_cnt} !== {3'd0, 2'd1})
         $display("FAIL error_clr: got %h expected %h", {state_o, fail_cnt}, {3'd0, 2'd1});
      else n_pass++;
   endtask

   task automatic enter_lockout();
      do_reset();
      tap(10'h020); pulse_clr();
      tap(10'h020); pulse_clr();
      tap(10'h080);
   endtask

   task automatic test_lockout();
      enter_lockout();
      n_checks++;
      if ({state_o, locked_out, fail_cnt, led} !== {3'd4, 1'b1, 2'd3, 10'h3ff})
         $display("FAIL lock_enter: got %h expected %h", {state_o, locked_out, fail_cnt, led}, {3'd4, 1'b1, 2'd3, 10'h3ff});
      else n_pass++;
      for (int e = 1; e <= 1000; e++) begin
         clr = (e == 10);
         if (e == 20) sw[2] = 1'b1;
         if (e == 21) sw[2] = 1'b0;
         @(negedge clk);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL lock_model_e%0d: got %h expected %h", e, dut_vec(), exp_vec());
         else n_pass++;
         if (e == 49 || e == 50 || e == 100) begin
            n_checks++;
            if (led !== ((e == 50) ? 10'h000 : 10'h3ff))
               $display("FAIL lock_blink_e%0d: got %h expected %h", e, led, (e == 50) ? 10'h000 : 10'h3ff);
            else n_pass++;
         end
         if (e == 999) begin
            n_checks++;
            if (state_o !== 3'd4) $display("FAIL lock_hold: got %0d expected 4", state_o);
            else n_pass++;
         end
      end
      n_checks++;
      if ({state_o, locked_out, fail_cnt, led} !== {3'd0, 1'b0, 2'd0, 10'h000})
         $display("FAIL lock_exit: got %h expected %h", {state_o, locked_out, fail_cnt, led}, 16'h0000);
      else n_pass++;
   endtask

   task automatic test_reset_in_lockout();
      enter_lockout();
      repeat (5) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if ({state_o, locked_out, fail_cnt, led} !== 16'h0000)
         $display("FAIL lock_async_rst: got %h expected %h", {state_o, locked_out, fail_cnt, led}, 16'h0000);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_timeout();
      do_reset();
      tap(10'h004);
      repeat (499) @(negedge clk);
      n_checks++;
      if ({state_o, digit_cnt} !== {3'd1, 3'd1}) $display("FAIL timeout_before: got %h expected %h", {state_o, digit_cnt}, {3'd1, 3'd1});
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({state_o, digit_cnt, fail_cnt} !== {3'd0, 3'd0, 2'd0})
         $display("FAIL timeout_after: got %h expected %h", {state_o, digit_cnt, fail_cnt}, 8'h00);
      else n_pass++;
   endtask

   task automatic test_multi_edge();
      do_reset();
      tap(10'h00c);
      n_checks++;
      if ({state_o, fail_cnt} !== {3'd2, 2'd1}) $display("FAIL multi_edge: got %h expected %h", {state_o, fail_cnt}, {3'd2, 2'd1});
      else n_pass++;
   endtask

   task automatic test_hold_through_reset();
      rst = 1'b0; clr = 1'b0; sw = 10'h004;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({state_o, digit_cnt} !== 6'd0) $display("FAIL hold_rst: got %h expected %h", {state_o, digit_cnt}, 6'd0);
      else n_pass++;
      sw = '0;
      @(negedge clk);
      tap(10'h004);
      n_checks++;
      if ({state_o, digit_cnt} !== {3'd1, 3'd1}) $display("FAIL hold_repress: got %h expected %h", {state_o, digit_cnt}, {3'd1, 3'd1});
      else n_pass++;
      clr = 1'b1;
      tap(10'h001);
      clr = 1'b0;
      n_checks++;
      if ({state_o, digit_cnt, fail_cnt} !== 8'h00) $display("FAIL clr_wins: got %h expected %h", {state_o, digit_cnt, fail_cnt}, 8'h00);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int seq [4];
      seq = '{2, 0, 1, 9};
      do_reset();
      for (int k = 0; k < 4; k++) tap(10'(1) << seq[k]);
      n_checks++;
      if ({state_o, unlocked} !== {3'd3, 1'b1}) $display("FAIL b2b_open: got %h expected %h", {state_o, unlocked}, {3'd3, 1'b1});
      else n_pass++;
   endtask

   task automatic test_random();
      logic [9:0] pend;
      int r;
      do_reset();
      pend = '0;
      for (int c = 0; c < 4000; c++) begin
         sw  = sw & ~pend;
         pend = '0;
         clr = 1'b0;
         r = $urandom_range(0, 99);
         if (r < 25 && m_digits < 4)  pend = 10'(1) << code[m_digits];
         else if (r < 37)             pend = 10'(1) << $urandom_range(0, 9);
         else if (r < 40)             pend = 10'($urandom());
         else if (r < 43)             clr = 1'b1;
         sw = sw | pend;
         @(negedge clk);
         n_checks++;
         if (dut_vec() !== exp_vec()) $display("FAIL random_c%0d: got %h expected %h", c, dut_vec(), exp_vec());
         else n_pass++;
      end
      sw = '0;
      clr = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_unlock();
      test_error();
      test_lockout();
      test_reset_in_lockout();
      test_timeout();
      test_multi_edge();
      test_hold_through_reset();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
